// File: rtl/any1_pkg.sv
// Shared types for the ANY1 memory queue: address width, access sizes and queue entry layout.
package any1_pkg;

  localparam int AWID = 32;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_WYDE  = 2'd1,
    SZ_TETRA = 2'd2,
    SZ_OCTA  = 2'd3
  } memsz_t;

  typedef struct packed {
    logic            st;
    memsz_t          sz;
    logic [AWID-1:0] ea;
    logic [63:0]     dat;
    logic [4:0]      tag;
  } memq_ent_t;

  // An aligned access never crosses an octa, so only the low three bits matter.
  function automatic logic misaligned(memsz_t sz, logic [2:0] off);
    case (sz)
      SZ_BYTE:  return 1'b0;
      SZ_WYDE:  return off[0];
      SZ_TETRA: return |off[1:0];
      default:  return |off;
    endcase
  endfunction

endpackage

// File: rtl/any1_memq_align.sv
// Byte-lane steering for one access: lane selects, store shift, load extract and sign-extend.
module any1_memq_align import any1_pkg::*; (
  input  logic [1:0]  sz,
  input  logic [2:0]  off,
  input  logic [63:0] st_dat,
  input  logic [63:0] ld_raw,
  output logic [7:0]  sel,
  output logic [63:0] st_lane,
  output logic [63:0] ld_dat,
  output logic        mis
);

  logic [63:0] sh;

  assign sh      = ld_raw >> {off, 3'b000};
  assign st_lane = st_dat << {off, 3'b000};
  assign mis     = misaligned(memsz_t'(sz), off);

  always_comb begin
    sel    = 8'h00;
    ld_dat = sh;
    case (memsz_t'(sz))
      SZ_BYTE:  begin sel = 8'h01 << off; ld_dat = {{56{sh[7]}},  sh[7:0]};  end
      SZ_WYDE:  begin sel = 8'h03 << off; ld_dat = {{48{sh[15]}}, sh[15:0]}; end
      SZ_TETRA: begin sel = 8'h0F << off; ld_dat = {{32{sh[31]}}, sh[31:0]}; end
      default:  begin sel = 8'hFF << off; ld_dat = sh;                       end
    endcase
  end

endmodule

// File: rtl/any1_memq.sv
// In-order memory op queue: a circular FIFO feeding a single-outstanding bus master,
// retiring each op with a one-cycle result pulse.
module any1_memq import any1_pkg::*; #(
  parameter int AWID   = any1_pkg::AWID,
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_v,
  output logic                     enq_rdy,
  input  logic                     enq_st,
  input  logic [1:0]               enq_sz,
  input  logic [AWID-1:0]          enq_ea,
  input  logic [63:0]              enq_dat,
  input  logic [4:0]               enq_tag,
  output logic                     bus_cyc,
  output logic                     bus_we,
  output logic [7:0]               bus_sel,
  output logic [AWID-1:0]          bus_adr,
  output logic [63:0]              bus_dat_o,
  input  logic                     bus_ack,
  input  logic [63:0]              bus_dat_i,
  output logic                     res_v,
  output logic [4:0]               res_tag,
  output logic [63:0]              res_dat,
  output logic                     res_err,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RET = 2'd2;

  memq_ent_t     q [QDEPTH];
  memq_ent_t     head;
  logic [PW-1:0] hd, tl;
  logic [1:0]    state;
  logic          idle, push, pop;

  // Head fields are only valid until the pop, so the in-flight op keeps its own copy.
  logic          cur_st;
  logic [1:0]    cur_sz;
  logic [2:0]    cur_off;
  logic [4:0]    cur_tag;

  logic [1:0]    a_sz;
  logic [2:0]    a_off;
  logic [7:0]    a_sel;
  logic [63:0]   a_stl, a_ld;
  logic          a_mis;

  assign head    = q[hd];
  assign idle    = (state == IDLE);
  assign enq_rdy = (count != FULL);
  assign push    = enq_v & enq_rdy;
  assign pop     = (idle & (count != '0) & a_mis) | ((state == BUS) & bus_ack);

  // One aligner serves both launch (head entry) and completion (in-flight op).
  assign a_sz  = idle ? 2'(head.sz) : cur_sz;
  assign a_off = idle ? head.ea[2:0] : cur_off;

  any1_memq_align u_align (
    .sz      (a_sz),
    .off     (a_off),
    .st_dat  (head.dat),
    .ld_raw  (bus_dat_i),
    .sel     (a_sel),
    .st_lane (a_stl),
    .ld_dat  (a_ld),
    .mis     (a_mis)
  );

  always_ff @(posedge clk)
    if (push) q[tl] <= '{st: enq_st, sz: memsz_t'(enq_sz), ea: enq_ea, dat: enq_dat, tag: enq_tag};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hd        <= '0;
      tl        <= '0;
      count     <= '0;
      bus_cyc   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_adr   <= '0;
      bus_dat_o <= '0;
      res_v     <= 1'b0;
      res_tag   <= '0;
      res_dat   <= '0;
      res_err   <= 1'b0;
      cur_st    <= 1'b0;
      cur_sz    <= '0;
      cur_off   <= '0;
      cur_tag   <= '0;
    end else begin
      if (push) tl <= tl + 1'b1;
      if (pop)  hd <= hd + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      res_v <= 1'b0;
      case (state)
        IDLE: if (count != '0) begin
          cur_st  <= head.st;
          cur_sz  <= 2'(head.sz);
          cur_off <= head.ea[2:0];
          cur_tag <= head.tag;
          if (a_mis) begin
            state   <= RET;
            res_v   <= 1'b1;
            res_err <= 1'b1;
            res_dat <= '0;
            res_tag <= head.tag;
          end else begin
            state     <= BUS;
            bus_cyc   <= 1'b1;
            bus_we    <= head.st;
            bus_sel   <= a_sel;
            bus_adr   <= {head.ea[AWID-1:3], 3'b000};
            bus_dat_o <= a_stl;
          end
        end
        BUS: if (bus_ack) begin
          state   <= RET;
          bus_cyc <= 1'b0;
          res_v   <= 1'b1;
          res_err <= 1'b0;
          res_tag <= cur_tag;
          res_dat <= cur_st ? 64'd0 : a_ld;
        end
        RET:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_any1_memq.sv
// Directed and randomized checks of any1_memq against an op-level queue model.
module tb_any1_memq;
  import any1_pkg::*;

  localparam int QD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enq_v, enq_rdy, enq_st;
  logic [1:0]        enq_sz;
  logic [AWID-1:0]   enq_ea;
  logic [63:0]       enq_dat;
  logic [4:0]        enq_tag;
  logic              bus_cyc, bus_we, bus_ack;
  logic [7:0]        bus_sel;
  logic [AWID-1:0]   bus_adr;
  logic [63:0]       bus_dat_o, bus_dat_i;
  logic              res_v, res_err;
  logic [4:0]        res_tag;
  logic [63:0]       res_dat;
  logic [$clog2(QD):0] count;

  any1_memq #(.AWID(AWID), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .enq_v(enq_v), .enq_rdy(enq_rdy), .enq_st(enq_st),
    .enq_sz(enq_sz), .enq_ea(enq_ea), .enq_dat(enq_dat), .enq_tag(enq_tag),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel), .bus_adr(bus_adr),
    .bus_dat_o(bus_dat_o), .bus_ack(bus_ack), .bus_dat_i(bus_dat_i),
    .res_v(res_v), .res_tag(res_tag), .res_dat(res_dat), .res_err(res_err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            st;
    logic [1:0]      sz;
    logic [AWID-1:0] ea;
    logic [63:0]     dat;
    logic [4:0]      tag;
  } op_t;

  op_t         q[$];
  logic [4:0]  rtag_log[$];
  bit          rerr_log[$];
  int          ncmp = 0, nfail = 0, nret = 0, nbus = 0, waitc = 0, ack_delay = 0;
  bit          last_acc, prev_bus, prev_resv, hold_ack, force_ack, rand_wait, rand_rd;
  logic [63:0] pend, next_rd, last_dat, last_dato;
  logic [7:0]  last_sel;
  logic        last_we;

  function automatic int nb(logic [1:0] sz); return 1 << sz; endfunction
  function automatic bit misal(op_t o); return (int'(o.ea[2:0]) % nb(o.sz)) != 0; endfunction
  function automatic logic [7:0] xsel(op_t o);
    int m;
    m = ((1 << nb(o.sz)) - 1) << o.ea[2:0];
    return m[7:0];
  endfunction
  function automatic logic [63:0] xld(logic [63:0] d, op_t o);
    logic [63:0] v, m;
    int n;
    n = nb(o.sz);
    v = d >> (8 * o.ea[2:0]);
    m = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    v = v & m;
    if (n < 8 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record what the edge accepts, then check every visible output against the model.
  task automatic tick();
    bit r, acc;
    op_t o;
    r   = rst;
    acc = enq_v && enq_rdy && !rst;
    o   = '{enq_st, enq_sz, enq_ea, enq_dat, enq_tag};
    if (!r && bus_cyc && bus_ack && q.size() > 0) pend = xld(bus_dat_i, q[0]);
    @(posedge clk); #1;
    last_acc = acc;
    if (r) begin
      q.delete();
      chk("rst_bus_cyc", bus_cyc, 0);   chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_sel", bus_sel, 0);   chk("rst_bus_adr", bus_adr, 0);
      chk("rst_bus_dat_o", bus_dat_o, 0); chk("rst_res_v", res_v, 0);
      chk("rst_res_tag", res_tag, 0);   chk("rst_res_dat", res_dat, 0);
      chk("rst_res_err", res_err, 0);   chk("rst_count", count, 0);
    end else if (acc) q.push_back(o);
    if (res_v) begin
      chk("res_has_op", q.size() != 0, 1);
      if (q.size() != 0) begin
        o = q.pop_front();
        nret++;
        chk("res_tag", res_tag, o.tag);
        chk("res_err", res_err, misal(o));
        if (!misal(o)) chk("res_dat", res_dat, o.st ? 64'd0 : pend);
        rtag_log.push_back(res_tag);
        rerr_log.push_back(res_err);
        last_dat = res_dat;
      end
    end
    chk("res_pulse", res_v & prev_resv, 0);
    chk("count", count, q.size());
    chk("enq_rdy", enq_rdy, q.size() != QD);
    if (bus_cyc) begin
      if (!prev_bus) nbus++;
      chk("bus_has_op", q.size() != 0, 1);
      if (q.size() != 0) begin
        o = q[0];
        chk("bus_aligned_op", misal(o), 0);
        chk("bus_adr", bus_adr, {o.ea[AWID-1:3], 3'b000});
        chk("bus_we", bus_we, o.st);
        chk("bus_sel", bus_sel, xsel(o));
        if (o.st) chk("bus_dat_o", bus_dat_o, o.dat << (8 * o.ea[2:0]));
        last_sel = bus_sel; last_dato = bus_dat_o; last_we = bus_we;
      end
    end
    prev_bus  = bus_cyc;
    prev_resv = res_v;
    // Bus slave: ack after waitc cycles; random ack noise while no cycle is active.
    if (force_ack) bus_ack = 1'b1;
    else if (bus_cyc) begin
      if (hold_ack) bus_ack = 1'b0;
      else if (waitc == 0) begin
        bus_ack   = 1'b1;
        bus_dat_i = rand_rd ? {$urandom, $urandom} : next_rd;
      end else begin
        waitc--;
        bus_ack = 1'b0;
      end
    end else begin
      bus_ack   = 1'($urandom % 2);
      bus_dat_i = {$urandom, $urandom};
      waitc     = rand_wait ? int'($urandom % 4) : ack_delay;
    end
  endtask

  task automatic enq_op(logic st, logic [1:0] sz, logic [AWID-1:0] ea, logic [63:0] dat, logic [4:0] tag);
    enq_st = st; enq_sz = sz; enq_ea = ea; enq_dat = dat; enq_tag = tag; enq_v = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("enq_accept", last_acc, 1);
    enq_v = 1'b0;
  endtask

  task automatic wait_ret(int n);
    for (int i = 0; i < 80 && nret < n; i++) tick();
    chk("ret_timeout", nret >= n, 1);
  endtask

  initial begin
    int base, nb0;
    rst = 1'b1; enq_v = 1'b0; enq_st = 1'b0; enq_sz = 2'd0; enq_ea = '0; enq_dat = '0; enq_tag = '0;
    bus_ack = 1'b0; bus_dat_i = '0; hold_ack = 0; force_ack = 0; rand_wait = 0; rand_rd = 0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Load octa, two wait states, enqueue-to-bus latency.
    ack_delay = 2; next_rd = 64'h1122334455667788;
    enq_op(1'b0, 2'd3, 32'h100, 64'd0, 5'd5);
    chk("lat_no_cyc_yet", bus_cyc, 0);
    tick();
    chk("lat_cyc", bus_cyc, 1);
    chk("ld_octa_sel", bus_sel, 8'hFF);
    wait_ret(1);
    chk("ld_octa_dat", last_dat, 64'h1122334455667788);
    chk("ld_octa_tag", rtag_log[rtag_log.size()-1], 5'd5);
    tick(); tick();

    // Store byte at lane 3.
    ack_delay = 0;
    enq_op(1'b1, 2'd0, 32'h103, 64'hAB, 5'd7);
    wait_ret(2);
    chk("st_byte_we", last_we, 1);
    chk("st_byte_sel", last_sel, 8'h08);
    chk("st_byte_lane", last_dato[31:24], 8'hAB);
    chk("st_byte_err", rerr_log[rerr_log.size()-1], 0);
    chk("st_byte_dat", last_dat, 64'd0);

    // Load wyde, negative value.
    ack_delay = 1; next_rd = 64'h5A5A5A5A80011234;
    enq_op(1'b0, 2'd1, 32'h102, 64'd0, 5'd8);
    wait_ret(3);
    chk("ld_wyde_sext", last_dat, 64'hFFFFFFFFFFFF8001);

    // Misaligned tetra then a normal op.
    nb0 = nbus;
    enq_op(1'b0, 2'd2, 32'h106, 64'd0, 5'd9);
    enq_op(1'b0, 2'd0, 32'h107, 64'd0, 5'd10);
    wait_ret(5);
    chk("misal_bus_cycles", nbus - nb0, 1);
    chk("misal_err", rerr_log[rerr_log.size()-2], 1);
    chk("misal_tag", rtag_log[rtag_log.size()-2], 5'd9);
    chk("next_ok_err", rerr_log[rerr_log.size()-1], 0);

    // Fill with ack withheld, then drain in order.
    tick(); tick();
    hold_ack = 1; ack_delay = 0; base = nret;
    for (int i = 0; i < 4; i++) enq_op(1'(i % 2), 2'd3, AWID'(32'h200 + 8 * i), {$urandom, $urandom}, 5'(11 + i));
    enq_st = 1'b0; enq_sz = 2'd2; enq_ea = 32'h300; enq_tag = 5'd15; enq_v = 1'b1;
    tick(); tick();
    chk("full_rdy", enq_rdy, 0);
    chk("full_count", count, 4);
    hold_ack = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("fifth_accept", last_acc, 1);
    enq_v = 1'b0;
    wait_ret(base + 5);
    for (int i = 0; i < 5; i++) chk("order_tag", rtag_log[rtag_log.size()-5+i], 5'(11 + i));

    // Randomized traffic with random ack latency and data.
    rand_wait = 1; rand_rd = 1;
    for (int i = 0; i < 500; i++) begin
      enq_v   = 1'($urandom % 2);
      enq_st  = 1'($urandom % 2);
      enq_sz  = 2'($urandom % 4);
      enq_ea  = AWID'($urandom);
      if ($urandom % 2) enq_ea[2:0] = (enq_ea[2:0] >> enq_sz) << enq_sz;
      enq_dat = {$urandom, $urandom};
      enq_tag = 5'($urandom);
      tick();
    end
    enq_v = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
    tick(); tick(); tick();

    // Reset while a bus cycle is open; a later ack must not retire anything.
    rand_wait = 0; rand_rd = 0; hold_ack = 1;
    enq_op(1'b0, 2'd3, 32'h400, 64'd0, 5'd20);
    for (int i = 0; i < 10 && !bus_cyc; i++) tick();
    chk("rst_mid_cyc_up", bus_cyc, 1);
    force_ack = 1; rst = 1'b1;
    tick();
    rst = 1'b0;
    base = nret;
    for (int i = 0; i < 5; i++) tick();
    chk("late_ack_no_ret", nret, base);
    chk("late_ack_count", count, 0);
    force_ack = 0; hold_ack = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
